// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl - UART transmit controller.
//
// Accepts one byte per valid/ready handshake and serialises it as a frame:
// start bit (0), DATA_BITS data bits LSB first, optional even parity bit,
// STOP_BITS stop bits (1). Bit timing comes from a down-counter running on
// clock_i that is reloaded at every bit boundary, so no derived clock exists.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state after DATA sends the XOR of the data bits
//   undefined -> DATA goes straight to STOP, no parity logic
//
// Ports:
//   clock_i     system clock, posedge
//   reset_i     asynchronous active-high reset
//   tx_data_i   byte to send, sampled only on acceptance
//   tx_valid_i  producer has tx_data_i available
//   tx_ready_o  controller can accept a byte (IDLE only)
//   tx_o        serial line, idles high
//   busy_o      high from the cycle after acceptance through the last stop cycle
//   done_o      one-cycle pulse in the first IDLE cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (0) for one bit period
// DATA   | data bits, LSB first, from the shift register
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s), line high

module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP  = 3'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign bit_end = (cnt_q == '0);

    // State and datapath registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state, bit timer, index (data bit or stop bit), shift register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_MAX : cnt_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tx_valid_i && ready_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                    shreg_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shreg_q[0];
`endif
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered pins
    // change on the same edge as the state itself.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       valid1 = 1'b0;
    logic       valid2 = 1'b0;
    logic       tx1, rdy1, busy1, done1;
    logic       tx2, rdy2, busy2, done2;

    int checks = 0;
    int failures = 0;
    int cur_sel = 0;

    logic obs_tx, obs_rdy, obs_busy, obs_done;

    always #5 clock = ~clock;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clock_i(clock), .reset_i(reset), .tx_data_i(tx_data), .tx_valid_i(valid1),
        .tx_ready_o(rdy1), .tx_o(tx1), .busy_o(busy1), .done_o(done1)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clock_i(clock), .reset_i(reset), .tx_data_i(tx_data), .tx_valid_i(valid2),
        .tx_ready_o(rdy2), .tx_o(tx2), .busy_o(busy2), .done_o(done2)
    );

    always_comb begin
        obs_tx   = (cur_sel == 0) ? tx1   : tx2;
        obs_rdy  = (cur_sel == 0) ? rdy1  : rdy2;
        obs_busy = (cur_sel == 0) ? busy1 : busy2;
        obs_done = (cur_sel == 0) ? done1 : done2;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends one byte on the selected instance, starting from an idle cycle
    // (#1 after a posedge), and checks the line against a frame built from
    // the UART framing rules. Leaves time in the done cycle if keep_valid,
    // otherwise one cycle later.
    task automatic frame_check(input int sel, input logic [7:0] data,
                               input bit keep_valid, input bit scramble,
                               input string name);
        logic bits[$];
        int   nstop;
        int   len;
        cur_sel = sel;
        nstop = (sel == 0) ? 1 : 2;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (PAR == 1) bits.push_back(^data);
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        len = bits.size() * CPB;

        tx_data = data;
        if (sel == 0) valid1 = 1'b1; else valid2 = 1'b1;
        step();                              // edge 0 has passed: cycle 1
        if (!keep_valid) begin
            valid1 = 1'b0;
            valid2 = 1'b0;
        end
        for (int k = 1; k <= len; k++) begin
            if (scramble) tx_data = 8'($urandom);
            checks++;
            if (obs_tx !== bits[(k-1)/CPB]) begin
                failures++;
                $display("FAIL %s tx cycle %0d: got %b want %b", name, k, obs_tx, bits[(k-1)/CPB]);
            end
            checks++;
            if ({obs_busy, obs_rdy, obs_done} !== 3'b100) begin
                failures++;
                $display("FAIL %s status cycle %0d: busy/ready/done got %b want 100",
                         name, k, {obs_busy, obs_rdy, obs_done});
            end
            step();
        end
        checks++;
        if ({obs_tx, obs_busy, obs_rdy, obs_done} !== 4'b1011) begin
            failures++;
            $display("FAIL %s done cycle %0d: tx/busy/ready/done got %b want 1011",
                     name, len + 1, {obs_tx, obs_busy, obs_rdy, obs_done});
        end
        if (!keep_valid) begin
            step();
            checks++;
            if ({obs_tx, obs_busy, obs_rdy, obs_done} !== 4'b1010) begin
                failures++;
                $display("FAIL %s after done: tx/busy/ready/done got %b want 1010",
                         name, {obs_tx, obs_busy, obs_rdy, obs_done});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({tx1, busy1, rdy1, done1, tx2, busy2, rdy2, done2} !== 8'b1010_1010) begin
            failures++;
            $display("FAIL reset_hold: got %b want 10101010",
                     {tx1, busy1, rdy1, done1, tx2, busy2, rdy2, done2});
        end
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({tx1, busy1, rdy1, done1, tx2, busy2, rdy2, done2} !== 8'b1010_1010) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %b want 10101010", i,
                         {tx1, busy1, rdy1, done1, tx2, busy2, rdy2, done2});
            end
        end
    endtask

    task automatic test_single();
        frame_check(0, 8'hA5, 1'b0, 1'b0, "frame_a5");
        step();
        frame_check(0, 8'h07, 1'b0, 1'b0, "frame_07");
    endtask

    task automatic test_back_to_back();
        frame_check(0, 8'h00, 1'b1, 1'b0, "b2b_first");
        frame_check(0, 8'hFF, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_midframe();
        cur_sel = 0;
        tx_data = 8'h3C;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        tx_data = 8'h00;
        for (int k = 1; k < 18; k++) step();   // cycle 18: data bit 3
        checks++;
        if ({tx1, busy1} !== 2'b11) begin
            failures++;
            $display("FAIL midframe_pre: tx/busy got %b want 11", {tx1, busy1});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tx1, busy1, rdy1, done1} !== 4'b1010) begin
            failures++;
            $display("FAIL midframe_reset: tx/busy/ready/done got %b want 1010",
                     {tx1, busy1, rdy1, done1});
        end
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({tx1, busy1, rdy1, done1} !== 4'b1010) begin
                failures++;
                $display("FAIL midframe_after cycle %0d: got %b want 1010", i,
                         {tx1, busy1, rdy1, done1});
            end
        end
        frame_check(0, 8'h81, 1'b0, 1'b0, "after_reset_81");
    endtask

    task automatic test_two_stop();
        step();
        frame_check(1, 8'hFF, 1'b0, 1'b1, "two_stop_ff");
        step();
        frame_check(1, 8'($urandom), 1'b0, 1'b1, "two_stop_rand");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                // valid pulse that never meets a clock edge must not start a frame
                tx_data = 8'($urandom);
                valid1 = 1'b1;
                #2 valid1 = 1'b0;
                step();
                checks++;
                if ({tx1, busy1, rdy1, done1} !== 4'b1010) begin
                    failures++;
                    $display("FAIL rand_idle %0d: got %b want 1010", n, {tx1, busy1, rdy1, done1});
                end
            end
            frame_check(0, 8'($urandom), 1'b0, 1'b0, "rand_frame");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        step();
        test_back_to_back();
        step();
        test_reset_midframe();
        test_two_stop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmit controller. Owns the bit-period counter and sequences one serial frame per accepted byte: start bit, data LSB-first, optional parity, stop bit(s).
- Replaces free-running baud clock dividers with a counter that is synchronous to `clock` and restarts on each frame, so there is no derived clock domain.
- Sits between the byte producer (valid/ready handshake) and the `tx` pin.

Parameters:
- CLKS_PER_BIT, 868, `clock` cycles per serial bit (100 MHz / 115200). Legal values are 2 or more.
- DATA_BITS, 8, data bits per frame. Legal range is 5 to 8.
- STOP_BITS, 1, number of stop bits. Legal values are 1 and 2.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on acceptance.
- tx_valid  input  1  producer has tx_data available.
- tx_ready  output  1  controller can accept a byte (high only in IDLE).
- tx  output  1  serial line; idles high.
- busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, tx=1, tx_ready=1, busy=0, done=0.
  - Bit counter and shift register are cleared.
  - Reset mid-frame aborts the frame with no partial stop bit; tx returns to 1 at once.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs are registered.
- IDLE:
  - tx=1, tx_ready=1, busy=0.
  - On a posedge with tx_valid&&tx_ready (acceptance edge, call it edge 0): latch tx_data into the shift register, clear the parity accumulator, load the bit counter with CLKS_PER_BIT-1, go to START.
  - From the cycle after edge 0: tx=0, tx_ready=0, busy=1.
- Bit timing:
  - Each bit holds tx constant for exactly CLKS_PER_BIT cycles.
  - The counter decrements every cycle; at 0 it reloads CLKS_PER_BIT-1 and advances to the next bit.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: tx=0 for one bit period, then go to DATA.
- DATA:
  - tx = shift register bit 0; shift right at each bit boundary.
  - A separate index counts 0 to DATA_BITS-1. After the last bit, go to PARITY if enabled, otherwise STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of the period go to IDLE. In that first IDLE cycle, done=1 for exactly one cycle, tx_ready=1 and busy=0.
- Frame length: (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles after edge 0, where P=1 if parity is enabled, else 0.
- Back-to-back transfers:
  - If tx_valid is held high, the next byte is accepted in the first IDLE cycle, i.e. the done cycle.
  - This leaves exactly one idle-high cycle between frames.
- tx_data and tx_valid are ignored while busy; changing tx_data mid-frame has no effect.
- tx_valid dropped before acceptance: no transfer, no state change.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA.
  - tx = XOR of all transmitted data bits (even parity) for one bit period.
  - Frame length grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity accumulator logic.
  - DATA goes directly to STOP.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated):
1. Reset asserted, then released with tx_valid=0 for 20 cycles -> tx=1, tx_ready=1, busy=0, done=0 throughout.
2. Send 0xA5 (accepted at edge 0) -> tx bits 0,1,0,1,0,0,1,0,1 then stop 1, each held 4 cycles. Start occupies cycles 1-4, data cycles 5-36, stop cycles 37-40. done=1 and tx_ready=1 in cycle 41 only.
3. Same as test 2 with UART_TX_PARITY_EN defined -> parity bit 0 in cycles 37-40, stop in cycles 41-44, done in cycle 45. Sending 0x07 gives parity bit 1.
4. tx_valid held high with 0x00 then 0xFF -> second byte accepted at edge 41. Its start bit begins cycle 42, giving exactly one idle-high cycle. Both frames are bit-exact.
5. Assert reset during data bit 3 of 0x3C -> tx=1 and tx_ready=1 immediately, no done pulse. A following send of 0x81 is transmitted correctly.
6. STOP_BITS=2: send 0xFF and toggle tx_data randomly mid-frame -> data bits all 1, stop lasts 8 cycles, done in cycle 45, and tx_data changes have no effect.
